// File: rtl/Verdata_pkg.sv
// rtl/Verdata_pkg.sv - shared datapath types: machine word, register index, decoded instruction
package Verdata_pkg;

    localparam int WORD_W = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] register_index_t;

    // Decoded instruction as handed down the pipeline; the register file only looks at rd/rs1/rs2/has_rd
    typedef struct packed {
        logic [6:0]      opcode;
        register_index_t rd;
        register_index_t rs1;
        register_index_t rs2;
        logic            has_rd;
        word_t           imm;
    } instruction_t;

endpackage

// File: rtl/Veropcodes_pkg.sv
// rtl/Veropcodes_pkg.sv - shared opcode constants, including the pipeline bubble instruction
package Veropcodes_pkg;

    import Verdata_pkg::*;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    // addi x0, x0, 0 with no destination: safe bubble that never writes the register file
    localparam instruction_t INSTR_NOP = '{
        opcode: OPC_OP_IMM,
        rd:     '0,
        rs1:    '0,
        rs2:    '0,
        has_rd: 1'b0,
        imm:    '0
    };

endpackage

// File: rtl/vergister.sv
// rtl/vergister.sv - integer register file, two combinational read ports, one write port, x0 hardwired to zero
module vergister
    import Verdata_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  instruction_t src_instr,
    input  instruction_t dest_instr,
    input  word_t        xd,
    output word_t        xs1,
    output word_t        xs2
);

    localparam int IDX_W = $clog2(SIZE);
    localparam logic [REG_IDX_W:0] SIZE_LIM = (REG_IDX_W+1)'(SIZE);

    word_t regs [SIZE];

    logic wr_en;
    logic rs1_valid;
    logic rs2_valid;

    // Index 0 and indices beyond the implemented range are neither writable nor readable
    assign wr_en = enable && dest_instr.has_rd && (dest_instr.rd != '0)
                   && ({1'b0, dest_instr.rd} < SIZE_LIM);
    assign rs1_valid = (src_instr.rs1 != '0) && ({1'b0, src_instr.rs1} < SIZE_LIM);
    assign rs2_valid = (src_instr.rs2 != '0) && ({1'b0, src_instr.rs2} < SIZE_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[dest_instr.rd[IDX_W-1:0]] <= xd;
        end
    end

    // No write-through: a read of the register being written sees the pre-edge value
    always_comb begin
        xs1 = '0;
        if (rs1_valid) begin
            xs1 = regs[src_instr.rs1[IDX_W-1:0]];
        end
    end

    always_comb begin
        xs2 = '0;
        if (rs2_valid) begin
            xs2 = regs[src_instr.rs2[IDX_W-1:0]];
        end
    end

    logic unused_fields;
    assign unused_fields = ^{src_instr.opcode, src_instr.rd, src_instr.has_rd, src_instr.imm,
                             dest_instr.opcode, dest_instr.rs1, dest_instr.rs2, dest_instr.imm};

endmodule

// File: tb/tb_vergister.sv
// tb/tb_vergister.sv - self-checking bench for vergister at SIZE=32 and SIZE=16
module tb_vergister;

    import Verdata_pkg::*;
    import Veropcodes_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    instruction_t src_instr = INSTR_NOP;
    instruction_t dest_instr = INSTR_NOP;
    word_t        xd = '0;
    word_t        xs1_a, xs2_a, xs1_b, xs2_b;

    int n_cmp = 0;
    int n_fail = 0;

    word_t m32 [32];
    word_t m16 [32];

    always #5 clk = ~clk;

    vergister #(.SIZE(32)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .src_instr(src_instr), .dest_instr(dest_instr),
        .xd(xd), .xs1(xs1_a), .xs2(xs2_a)
    );

    vergister #(.SIZE(16)) dut16 (
        .clk(clk), .reset(reset), .enable(enable),
        .src_instr(src_instr), .dest_instr(dest_instr),
        .xd(xd), .xs1(xs1_b), .xs2(xs2_b)
    );

    typedef struct {
        register_index_t rd;
        logic            has_rd;
        logic            en;
        word_t           xd;
        register_index_t rs1;
        register_index_t rs2;
        word_t           pre1;
        word_t           post1;
        word_t           post2;
    } vec_t;

    vec_t tbl [5];

    function automatic word_t mread(input int size, input int idx);
        if (idx == 0 || idx >= size) return '0;
        return (size == 32) ? m32[idx] : m16[idx];
    endfunction

    function automatic void mclear();
        for (int i = 0; i < 32; i++) begin
            m32[i] = '0;
            m16[i] = '0;
        end
    endfunction

    // Applied right after a rising edge, with the inputs that were present at that edge
    function automatic void mwrite();
        int r;
        r = int'(dest_instr.rd);
        if (reset && enable && dest_instr.has_rd && r != 0) begin
            m32[r] = xd;
            if (r < 16) m16[r] = xd;
        end
    endfunction

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".a1"}, xs1_a, mread(32, int'(src_instr.rs1)));
        chk({nm, ".a2"}, xs2_a, mread(32, int'(src_instr.rs2)));
        chk({nm, ".b1"}, xs1_b, mread(16, int'(src_instr.rs1)));
        chk({nm, ".b2"}, xs2_b, mread(16, int'(src_instr.rs2)));
    endtask

    task automatic set_io(input register_index_t rd, input logic has, input logic en,
                          input word_t d, input register_index_t r1, input register_index_t r2);
        src_instr = INSTR_NOP;
        src_instr.rs1 = r1;
        src_instr.rs2 = r2;
        dest_instr = INSTR_NOP;
        dest_instr.rd = rd;
        dest_instr.has_rd = has;
        enable = en;
        xd = d;
    endtask

    task automatic tick();
        @(posedge clk);
        mwrite();
        #1;
    endtask

    initial begin
        word_t e1, e2;
        mclear();

        // Reset, held across edges with a write pending
        #3 reset = 1'b0;
        set_io(5'd4, 1'b1, 1'b1, 32'h55555555, 5'd4, 5'd31);
        #1;
        chk("rst.xs1", xs1_a, 32'h0);
        chk("rst.xs2", xs2_a, 32'h0);
        tick();
        chk("rst.blocked", xs1_a, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        set_io(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);

        // Fill x[n] = (n+1)<<12, then read neighbouring pairs
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            set_io(5'(n), (n > 0), 1'b1, word_t'((n + 1) << 12), 5'd0, 5'd0);
            tick();
        end
        for (int n = 0; n < 31; n++) begin
            @(negedge clk);
            set_io(5'd0, 1'b0, 1'b0, 32'h0, 5'(n), 5'(n + 1));
            #1;
            e1 = (n == 0) ? 32'h0 : word_t'((n + 1) << 12);
            e2 = word_t'((n + 2) << 12);
            chk($sformatf("fill32.rs1_%0d", n), xs1_a, e1);
            chk($sformatf("fill32.rs2_%0d", n + 1), xs2_a, e2);
            chk($sformatf("fill16.rs1_%0d", n), xs1_b, (n < 16) ? e1 : 32'h0);
            chk($sformatf("fill16.rs2_%0d", n + 1), xs2_b, (n + 1 < 16) ? e2 : 32'h0);
        end

        // Directed vectors over the filled state
        tbl[0] = '{5'd5, 1'b1, 1'b0, 32'hDEADBEEF, 5'd5, 5'd5, 32'h00006000, 32'h00006000, 32'h00006000};
        tbl[1] = '{5'd5, 1'b0, 1'b1, 32'hDEADBEEF, 5'd5, 5'd6, 32'h00006000, 32'h00006000, 32'h00007000};
        tbl[2] = '{5'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000000};
        tbl[3] = '{5'd7, 1'b1, 1'b1, 32'h12345678, 5'd7, 5'd7, 32'h00008000, 32'h12345678, 32'h12345678};
        tbl[4] = '{5'd31, 1'b1, 1'b1, 32'hA5A5A5A5, 5'd31, 5'd30, 32'h00020000, 32'hA5A5A5A5, 32'h0001F000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_io(tbl[i].rd, tbl[i].has_rd, tbl[i].en, tbl[i].xd, tbl[i].rs1, tbl[i].rs2);
            #1;
            chk($sformatf("vec%0d.pre1", i), xs1_a, tbl[i].pre1);
            chk_model($sformatf("vec%0d.pre", i));
            tick();
            chk($sformatf("vec%0d.post1", i), xs1_a, tbl[i].post1);
            chk($sformatf("vec%0d.post2", i), xs2_a, tbl[i].post2);
            chk_model($sformatf("vec%0d.post", i));
        end

        // Out-of-range write on the 16-entry file
        @(negedge clk);
        set_io(5'd20, 1'b1, 1'b1, 32'h11111111, 5'd20, 5'd4);
        tick();
        chk("size16.rd20", xs1_b, 32'h0);
        chk("size16.x4", xs2_b, 32'h00005000);
        chk("size32.rd20", xs1_a, 32'h11111111);

        // Randomised traffic against the model, including junk in ignored fields
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            set_io(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) src_instr.rs2 = src_instr.rs1;
            src_instr.opcode = 7'($urandom);
            src_instr.imm = $urandom;
            src_instr.rd = 5'($urandom);
            src_instr.has_rd = 1'($urandom);
            dest_instr.opcode = 7'($urandom);
            dest_instr.rs1 = 5'($urandom);
            dest_instr.rs2 = 5'($urandom);
            dest_instr.imm = $urandom;
            #1;
            chk_model($sformatf("rand%0d", k));
            tick();
        end

        // Asynchronous reset between edges, with priority over a concurrent write
        @(negedge clk);
        set_io(5'd12, 1'b1, 1'b1, 32'hCAFEF00D, 5'd12, 5'd9);
        tick();
        chk("arst.loaded", xs1_a, 32'hCAFEF00D);
        @(negedge clk);
        set_io(5'd9, 1'b1, 1'b1, 32'h99999999, 5'd12, 5'd9);
        #2 reset = 1'b0;
        #1;
        mclear();
        chk("arst.x12", xs1_a, 32'h0);
        chk("arst.x12_16", xs1_b, 32'h0);
        tick();
        chk("arst.x9_blocked", xs2_a, 32'h0);
        chk_model("arst.held");
        @(negedge clk);
        reset = 1'b1;
        set_io(5'd3, 1'b1, 1'b1, 32'h00000042, 5'd3, 5'd3);
        #1;
        chk("arst.x3_pre", xs1_a, 32'h0);
        tick();
        chk("arst.x3_post", xs1_a, 32'h00000042);
        chk("arst.x3_post16", xs2_b, 32'h00000042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
